hhmm_countdown_core: RTL

BCD hours:minutes countdown engine for the lab timer. It consumes the one-pulse button events (set minute, set hour, start, pause), the setting switch, and a timebase tick from the frequency divider. It produces four BCD digits for the seven-segment decoders, plus status and LED outputs for the display stage. It replaces the loosely coupled per-field counters and toggle FSMs with a single state machine that owns the preset, the live count, and expiry.

---
 rtl/timer_pkg.sv | 49 ++++
 rtl/bcd_field_dec.sv | 37 +++
 rtl/hhmm_countdown_core.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the HH:MM countdown timer.
// Latency: n/a (types, constants and a pure combinational helper).
// Backpressure: n/a.
package timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t ten_h;
        bcd_t one_h;
        bcd_t ten_m;
        bcd_t one_m;
    } hhmm_t;

    // Minutes always run 00..59.
    localparam bcd_t MIN_MAX_TENS = 4'd5;
    localparam bcd_t MIN_MAX_ONES = 4'd9;

    localparam logic [15:0] LED_OFF   = 16'h0000;
    localparam logic [15:0] LED_RUN   = 16'h0001;
    localparam logic [15:0] LED_PAUSE = 16'h0002;
    localparam logic [15:0] LED_DONE  = 16'hFFFF;

    // Two-digit BCD increment that wraps to 00 after {max_tens,max_ones}.
    // Returns {tens, ones}.
    function automatic logic [7:0] bcd_inc_wrap(input bcd_t tens,
                                                 input bcd_t ones,
                                                 input bcd_t max_tens,
                                                 input bcd_t max_ones);
        logic [7:0] res;
        if (tens == max_tens && ones == max_ones) begin
            res = 8'h00;
        end else if (ones == 4'd9) begin
            res = {tens + 4'd1, 4'd0};
        end else begin
            res = {tens, ones + 4'd1};
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_field_dec.sv
// Two-digit BCD decrement with borrow-in/borrow-out; 00 wraps to {WRAP_TENS,WRAP_ONES}.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input immediately.
module bcd_field_dec
    import timer_pkg::*;
#(
    parameter bcd_t WRAP_TENS = 4'd5,
    parameter bcd_t WRAP_ONES = 4'd9
) (
    input  bcd_t tens_i,
    input  bcd_t ones_i,
    input  logic borrow_i,
    output bcd_t tens_o,
    output bcd_t ones_o,
    output logic borrow_o
);

    // Decrement by one when a borrow arrives; pass through otherwise.
    always_comb begin
        tens_o   = tens_i;
        ones_o   = ones_i;
        borrow_o = 1'b0;
        if (borrow_i) begin
            if (tens_i == 4'd0 && ones_i == 4'd0) begin
                tens_o   = WRAP_TENS;
                ones_o   = WRAP_ONES;
                borrow_o = 1'b1;
            end else if (ones_i == 4'd0) begin
                ones_o = 4'd9;
                tens_o = tens_i - 4'd1;
            end else begin
                ones_o = ones_i - 4'd1;
            end
        end
    end

endmodule

// File: rtl/hhmm_countdown_core.sv
// BCD HH:MM countdown engine: owns preset, live count, run/pause/expiry FSM.
// Latency: every input event shows on the registered outputs one cycle later.
// Backpressure: none; pulses are consumed in the cycle they arrive.
// Optional feature: define HHMM_COUNTDOWN_FLASH_EN to make the DONE LEDs toggle on each tick.
module hhmm_countdown_core
    import timer_pkg::*;
#(
    parameter int MAX_HOUR = 23
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        setting,
    input  logic        set_min,
    input  logic        set_hour,
    input  logic        start,
    input  logic        pause,
    output logic [3:0]  one_m,
    output logic [3:0]  ten_m,
    output logic [3:0]  one_h,
    output logic [3:0]  ten_h,
    output logic        running,
    output logic        done,
    output logic [15:0] led
);

    localparam bcd_t MAXH_TENS = bcd_t'(MAX_HOUR / 10);
    localparam bcd_t MAXH_ONES = bcd_t'(MAX_HOUR % 10);

    state_e      state_q, state_d;
    hhmm_t       preset_q, preset_d;
    hhmm_t       count_q, count_d;
    logic        running_q, running_d;
    logic        done_q, done_d;
    logic [15:0] led_q, led_d;

`ifdef HHMM_COUNTDOWN_FLASH_EN
    logic        flash_q, flash_d;
`endif

    bcd_t dec_ten_m, dec_one_m, dec_ten_h, dec_one_h;
    logic min_borrow, hour_borrow;
    logic [7:0] min_inc, hour_inc;
    logic dec_zero;

    bcd_field_dec #(
        .WRAP_TENS (MIN_MAX_TENS),
        .WRAP_ONES (MIN_MAX_ONES)
    ) u_dec_min (
        .tens_i   (count_q.ten_m),
        .ones_i   (count_q.one_m),
        .borrow_i (tick),
        .tens_o   (dec_ten_m),
        .ones_o   (dec_one_m),
        .borrow_o (min_borrow)
    );

    bcd_field_dec #(
        .WRAP_TENS (MAXH_TENS),
        .WRAP_ONES (MAXH_ONES)
    ) u_dec_hour (
        .tens_i   (count_q.ten_h),
        .ones_i   (count_q.one_h),
        .borrow_i (min_borrow),
        .tens_o   (dec_ten_h),
        .ones_o   (dec_one_h),
        .borrow_o (hour_borrow)
    );

    assign min_inc  = bcd_inc_wrap(preset_q.ten_m, preset_q.one_m, MIN_MAX_TENS, MIN_MAX_ONES);
    assign hour_inc = bcd_inc_wrap(preset_q.ten_h, preset_q.one_h, MAXH_TENS, MAXH_ONES);
    assign dec_zero = (dec_ten_h == 4'd0) && (dec_one_h == 4'd0) &&
                      (dec_ten_m == 4'd0) && (dec_one_m == 4'd0);

    // Next-state, preset/count update and registered-output decode.
    always_comb begin
        state_d  = state_q;
        preset_d = preset_q;
        count_d  = count_q;
`ifdef HHMM_COUNTDOWN_FLASH_EN
        flash_d  = flash_q;
`endif
        if (setting) begin
            // Setting wins over everything; increments only apply once already in SET.
            state_d = ST_SET;
            if (state_q == ST_SET) begin
                if (set_min)  {preset_d.ten_m, preset_d.one_m} = min_inc;
                if (set_hour) {preset_d.ten_h, preset_d.one_h} = hour_inc;
            end
            count_d = preset_d;
        end else begin
            case (state_q)
                ST_SET: state_d = ST_IDLE;
                ST_IDLE: begin
                    if (start && count_q != '0) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (tick) begin
                        count_d = hhmm_t'({dec_ten_h, dec_one_h, dec_ten_m, dec_one_m});
                    end
                    // An hour borrow means the count was already 00:00: treat as expiry.
                    if (tick && (dec_zero || hour_borrow)) begin
                        count_d = '0;
                        state_d = ST_DONE;
                    end else if (pause) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (start || pause) state_d = ST_RUN;
                end
                ST_DONE: begin
                    count_d = '0;
                    if (start) begin
                        count_d = preset_q;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

`ifdef HHMM_COUNTDOWN_FLASH_EN
        if (state_d == ST_DONE) begin
            if (state_q != ST_DONE) flash_d = 1'b1;
            else if (tick)          flash_d = ~flash_q;
        end
`endif

        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
        case (state_d)
            ST_RUN:   led_d = LED_RUN;
            ST_PAUSE: led_d = LED_PAUSE;
`ifdef HHMM_COUNTDOWN_FLASH_EN
            ST_DONE:  led_d = flash_d ? LED_DONE : LED_OFF;
`else
            ST_DONE:  led_d = LED_DONE;
`endif
            default:  led_d = LED_OFF;
        endcase
    end

    // State, preset, count and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            preset_q  <= '0;
            count_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            led_q     <= LED_OFF;
        end else begin
            state_q   <= state_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            running_q <= running_d;
            done_q    <= done_d;
            led_q     <= led_d;
        end
    end

`ifdef HHMM_COUNTDOWN_FLASH_EN
    // DONE flash phase; set on DONE entry, toggled by ticks while expired.
    always_ff @(posedge clk) begin
        if (rst) flash_q <= 1'b0;
        else     flash_q <= flash_d;
    end
`endif

    assign one_m   = count_q.one_m;
    assign ten_m   = count_q.ten_m;
    assign one_h   = count_q.one_h;
    assign ten_h   = count_q.ten_h;
    assign running = running_q;
    assign done    = done_q;
    assign led     = led_q;

endmodule
